// File: rtl/user_input_pkg.sv
// Shared types for the PS/2 user-input front end: event codes,
// scan-code constants, prefix FSM states and the key map.
package user_input_pkg;

    typedef enum logic [2:0] {
        EV_LEFT     = 3'd0,
        EV_RIGHT    = 3'd1,
        EV_DOWN     = 3'd2,
        EV_ROTATE   = 3'd3,
        EV_NEW_GAME = 3'd4
    } event_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_N      = 8'h31;
    localparam logic [7:0] SC_ROTATE = 8'h75;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } pfx_state_e;

    typedef struct packed {
        logic   hit;
        event_e ev;
    } key_t;

    // Arrows only count when E0-prefixed; the plain codes are keypad keys.
    function automatic key_t map_key(logic ext, logic [7:0] code);
        key_t k;
        k.hit = 1'b1;
        k.ev  = EV_LEFT;
        if (!ext && code == SC_N)
            k.ev = EV_NEW_GAME;
        else if (ext && code == SC_ROTATE)
            k.ev = EV_ROTATE;
        else if (ext && code == SC_LEFT)
            k.ev = EV_LEFT;
        else if (ext && code == SC_RIGHT)
            k.ev = EV_RIGHT;
        else if (ext && code == SC_DOWN)
            k.ev = EV_DOWN;
        else
            k.hit = 1'b0;
        return k;
    endfunction

    function automatic logic is_repeatable(event_e ev);
        return (ev == EV_LEFT) || (ev == EV_RIGHT)
            || (ev == EV_DOWN);
    endfunction

endpackage

// File: rtl/user_event_sync_fifo.sv
// Synchronous show-ahead event FIFO with a sticky overflow flag.
// Head entry is always visible on dout_o; a pop advances it.
module user_event_sync_fifo #(
    parameter int DWIDTH = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic              pop_i,
    output logic [DWIDTH-1:0] dout_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot, so a full FIFO still takes a push then.
    assign do_push = push_i && (!full || do_pop);
    assign dout_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (push_i && full && !pop_i)
                overflow_o <= 1'b1;
        end
    end

endmodule

// File: rtl/user_input_decoder.sv
// PS/2 set-2 scan-code decoder producing game events, with held-key
// tracking, movement auto-repeat and an event FIFO for the game logic.
module user_input_decoder
    import user_input_pkg::*;
#(
    parameter int EV_WIDTH      = 3,
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          ps2_key_data_i,
    input  logic                ps2_key_data_en_i,
    input  logic                repeat_en_i,
    input  logic                user_event_rd_req_i,
    output logic [EV_WIDTH-1:0] user_event_o,
    output logic                user_event_ready_o,
    output logic                overflow_o
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                        ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD);
    localparam logic [TW-1:0] T_ONE    = TW'(1);

    pfx_state_e    state;
    logic [4:0]    held;
    logic          trk_active;
    event_e        trk_key;
    logic [TW-1:0] timer;
    logic          pend;
    event_e        pend_key;

    logic          fin;
    logic          ext;
    logic          brk;
    key_t          key;
    logic          make_hit;
    logic          brk_hit;
    logic          make_push;
    logic          brk_trk;
    logic          retarget;
    logic          tick;
    logic          pend_fire;
    logic          to_idle;
    logic          push;
    event_e        push_ev;
    logic          empty;

    always_comb begin
        fin = 1'b0;
        ext = 1'b0;
        brk = 1'b0;
        if (ps2_key_data_en_i) begin
            unique case (state)
                PS_IDLE: begin
                    fin = (ps2_key_data_i != SC_EXT)
                       && (ps2_key_data_i != SC_BRK);
                end
                PS_EXT: begin
                    fin = (ps2_key_data_i != SC_BRK);
                    ext = 1'b1;
                end
                PS_BRK: begin
                    fin = 1'b1;
                    brk = 1'b1;
                end
                PS_EXT_BRK: begin
                    fin = 1'b1;
                    ext = 1'b1;
                    brk = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign key       = map_key(ext, ps2_key_data_i);
    assign make_hit  = fin && !brk && key.hit;
    assign brk_hit   = fin && brk && key.hit;
    // Typematic makes of an already-held key are swallowed here.
    assign make_push = make_hit && !held[key.ev];

    assign brk_trk  = brk_hit && trk_active
                   && (key.ev == trk_key);
    assign retarget = make_hit && repeat_en_i
                   && is_repeatable(key.ev)
                   && (!held[key.ev] || !trk_active
                       || (trk_key != key.ev));
    assign to_idle  = !repeat_en_i || brk_trk;
    assign tick     = trk_active && repeat_en_i
                   && held[trk_key] && !brk_trk
                   && (timer == T_ONE);

    assign pend_fire = pend && trk_active;
    assign push      = make_push || pend_fire || tick;

    always_comb begin
        push_ev = trk_key;
        if (make_push)
            push_ev = key.ev;
        else if (pend_fire)
            push_ev = pend_key;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= PS_IDLE;
        end else if (ps2_key_data_en_i) begin
            unique case (state)
                PS_IDLE: begin
                    if (ps2_key_data_i == SC_EXT)
                        state <= PS_EXT;
                    else if (ps2_key_data_i == SC_BRK)
                        state <= PS_BRK;
                    else
                        state <= PS_IDLE;
                end
                PS_EXT: begin
                    if (ps2_key_data_i == SC_BRK)
                        state <= PS_EXT_BRK;
                    else
                        state <= PS_IDLE;
                end
                default: state <= PS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held <= '0;
        end else if (make_hit) begin
            held[key.ev] <= 1'b1;
        end else if (brk_hit) begin
            held[key.ev] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trk_active <= 1'b0;
            trk_key    <= EV_LEFT;
            timer      <= '0;
        end else if (to_idle) begin
            trk_active <= 1'b0;
        end else if (retarget) begin
            trk_active <= 1'b1;
            trk_key    <= key.ev;
            timer      <= T_DELAY;
        end else if (tick) begin
            timer <= T_PERIOD;
        end else if (trk_active && timer > T_ONE) begin
            timer <= timer - T_ONE;
        end
    end

    // A tick that loses to a decoded make waits one cycle here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend     <= 1'b0;
            pend_key <= EV_LEFT;
        end else if (to_idle) begin
            pend <= 1'b0;
        end else if (make_push) begin
            pend <= pend_fire || tick;
            if (tick)
                pend_key <= trk_key;
        end else begin
            pend     <= pend_fire && tick;
            pend_key <= trk_key;
        end
    end

    user_event_sync_fifo #(
        .DWIDTH (EV_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .din_i      (EV_WIDTH'(push_ev)),
        .pop_i      (user_event_rd_req_i),
        .dout_o     (user_event_o),
        .empty_o    (empty),
        .overflow_o (overflow_o)
    );

    assign user_event_ready_o = !empty;

endmodule

// File: tb/tb_user_input_decoder.sv
// Self-checking bench for user_input_decoder: vector table, directed
// repeat/reset sequences and a randomized run against a queue model.
module tb_user_input_decoder;

    localparam int DEPTH = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 4;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       strobe;
    logic       rep_en;
    logic       rd;
    logic [2:0] ev;
    logic       ready;
    logic       ovf;

    int checks = 0;
    int passes = 0;

    user_input_decoder #(
        .EV_WIDTH      (3),
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ps2_key_data_i      (data),
        .ps2_key_data_en_i   (strobe),
        .repeat_en_i         (rep_en),
        .user_event_rd_req_i (rd),
        .user_event_o        (ev),
        .user_event_ready_o  (ready),
        .overflow_o          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
    endtask

    typedef struct {
        bit         en;
        logic [7:0] d;
        bit         rd;
        bit         rdy;
        int         ev;
        bit         ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit en, logic [7:0] d, bit r,
                                bit rdy, int e, bit o);
        vec_t v;
        v.en = en; v.d = d; v.rd = r;
        v.rdy = rdy; v.ev = e; v.ovf = o;
        tbl.push_back(v);
    endfunction

    task automatic cyc(bit en, logic [7:0] d, bit r);
        strobe = en;
        data   = d;
        rd     = r;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        rd     = 1'b0;
    endtask

    task automatic do_reset();
        strobe = 1'b0;
        rd     = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Repeat-test monitor: pops every event it sees and logs its cycle.
    int  eidx;
    bit  popn;
    int  log_t[$];
    int  log_e[$];

    task automatic step(bit en, logic [7:0] d);
        strobe = en;
        data   = d;
        rd     = popn;
        @(posedge clk);
        #1;
        eidx++;
        if (ready) begin
            log_t.push_back(eidx);
            log_e.push_back(int'(ev));
        end
        popn = ready;
    endtask

    // Reference model for the randomized run (no auto-repeat there).
    int  mq[$];
    bit  m_ext, m_brk, m_ovf;
    bit  m_held[5];

    function automatic int m_map(bit e, logic [7:0] c);
        if (!e && c == 8'h31) return 4;
        if (e && c == 8'h75) return 3;
        if (e && c == 8'h6B) return 0;
        if (e && c == 8'h74) return 1;
        if (e && c == 8'h72) return 2;
        return -1;
    endfunction

    function automatic void m_cycle(bit en, logic [7:0] d, bit r);
        int k;
        bit pushing;
        pushing = 1'b0;
        k = -1;
        if (en) begin
            if (d == 8'hE0 && !m_ext && !m_brk) begin
                m_ext = 1'b1;
            end else if (d == 8'hF0 && !m_brk) begin
                m_brk = 1'b1;
            end else begin
                k = m_map(m_ext, d);
                if (k >= 0) begin
                    if (m_brk) begin
                        m_held[k] = 1'b0;
                    end else if (!m_held[k]) begin
                        m_held[k] = 1'b1;
                        pushing = 1'b1;
                    end
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        if (r && mq.size() > 0)
            void'(mq.pop_front());
        if (pushing) begin
            if (mq.size() < DEPTH) mq.push_back(k);
            else m_ovf = 1'b1;
        end
    endfunction

    logic [7:0] pool [8];
    int exp_t[$];
    int exp_e[$];

    initial begin
        rst = 1'b1;
        data = 8'h00;
        strobe = 1'b0;
        rep_en = 1'b0;
        rd = 1'b0;
        pool = '{8'hE0, 8'hF0, 8'h31, 8'h75,
                 8'h6B, 8'h74, 8'h72, 8'h1C};

        // Vector table: one row per cycle, repeat disabled
        add(1, 8'hE0, 0, 0, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'hF0, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h31, 0, 1, 4, 0);
        add(1, 8'hF0, 0, 1, 4, 0);
        add(1, 8'h31, 0, 1, 4, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(1, 8'hE0, 0, k > 0, 3, 0);
            add(1, 8'h75, 0, 1, 3, 0);
        end
        add(1, 8'hE0, 0, 1, 3, 0);
        add(1, 8'hF0, 0, 1, 3, 0);
        add(1, 8'h75, 0, 1, 3, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h6B, 0, 0, 0, 0);
        // overflow: L R L R L R makes, no pops
        add(1, 8'hE0, 0, 0, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'h74, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'hF0, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'hF0, 0, 1, 0, 0);
        add(1, 8'h74, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'h74, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'hF0, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 0);
        add(1, 8'hE0, 0, 1, 0, 0);
        add(1, 8'h6B, 0, 1, 0, 1);
        add(1, 8'hE0, 0, 1, 0, 1);
        add(1, 8'hF0, 0, 1, 0, 1);
        add(1, 8'h74, 0, 1, 0, 1);
        add(1, 8'hE0, 0, 1, 0, 1);
        add(1, 8'h74, 0, 1, 0, 1);
        add(1, 8'hE0, 0, 1, 0, 1);
        add(1, 8'hF0, 0, 1, 0, 1);
        add(1, 8'h6B, 0, 1, 0, 1);
        add(1, 8'hE0, 0, 1, 0, 1);
        add(1, 8'h6B, 1, 1, 1, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 1, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready), 0);
        chk("rst_event", int'(ev), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].d, tbl[i].rd);
            chk($sformatf("tbl%0d_ready", i),
                int'(ready), int'(tbl[i].rdy));
            if (tbl[i].rdy)
                chk($sformatf("tbl%0d_event", i),
                    int'(ev), tbl[i].ev);
            chk($sformatf("tbl%0d_ovf", i),
                int'(ovf), int'(tbl[i].ovf));
        end

        // Reset mid-sequence, right after an E0
        cyc(1, 8'h31, 0);
        chk("pre_rst_ready", int'(ready), 1);
        cyc(1, 8'hE0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", int'(ready), 0);
        chk("mid_rst_event", int'(ev), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 8'h6B, 0);
        chk("post_rst_plain6b", int'(ready), 0);
        cyc(1, 8'hE0, 0);
        cyc(1, 8'h6B, 0);
        chk("post_rst_left_ready", int'(ready), 1);
        chk("post_rst_left_event", int'(ev), 0);

        // Randomized run against the queue model
        do_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0;
        foreach (m_held[i]) m_held[i] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bit         en;
            bit         r;
            logic [7:0] d;
            en = ($urandom_range(99) < 60);
            r  = ($urandom_range(99) < 25);
            d  = pool[$urandom_range(7)];
            cyc(en, d, r);
            m_cycle(en, d, r);
            chk("rnd_ready", int'(ready), int'(mq.size() > 0));
            if (mq.size() > 0)
                chk("rnd_event", int'(ev), mq[0]);
            chk("rnd_ovf", int'(ovf), int'(m_ovf));
        end

        // DOWN auto-repeat, break 30 cycles after the make
        do_reset();
        rep_en = 1'b1;
        popn = 0;
        log_t.delete(); log_e.delete();
        step(1, 8'hE0);
        log_t.delete(); log_e.delete();
        eidx = -1;
        step(1, 8'h72);
        for (int c = 1; c <= 27; c++) step(0, 8'h00);
        step(1, 8'hE0);
        step(1, 8'hF0);
        step(1, 8'h72);
        for (int c = 0; c < 20; c++) step(0, 8'h00);
        exp_t = '{0, 10, 14, 18, 22, 26};
        chk("rep_count", log_t.size(), exp_t.size());
        foreach (exp_t[i]) begin
            chk($sformatf("rep%0d_time", i),
                (i < log_t.size()) ? log_t[i] : -1, exp_t[i]);
            chk($sformatf("rep%0d_event", i),
                (i < log_e.size()) ? log_e[i] : -1, 2);
        end

        // ROTATE make colliding with the first DOWN repeat tick
        do_reset();
        popn = 0;
        step(1, 8'hE0);
        log_t.delete(); log_e.delete();
        eidx = -1;
        step(1, 8'h72);
        for (int c = 1; c <= 8; c++) step(0, 8'h00);
        step(1, 8'hE0);
        step(1, 8'h75);
        for (int c = 11; c <= 15; c++) step(0, 8'h00);
        exp_t = '{0, 10, 11, 14};
        exp_e = '{2, 3, 2, 2};
        chk("col_count", log_t.size(), exp_t.size());
        foreach (exp_t[i]) begin
            chk($sformatf("col%0d_time", i),
                (i < log_t.size()) ? log_t[i] : -1, exp_t[i]);
            chk($sformatf("col%0d_event", i),
                (i < log_e.size()) ? log_e[i] : -1, exp_e[i]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
